// File: rtl/task_conflict_checker_if.sv
// task_conflict_checker_if: shared task types plus FIFO/issue/finish bundle between the FIFO, the checker and the core.
package task_conflict_checker_pkg;
    typedef logic [7:0] hint_t;
    typedef struct packed {
        hint_t       hint;
        logic [23:0] payload;
    } task_t;
    typedef logic [3:0] cq_slice_slot_t;
endpackage

interface task_conflict_checker_if #(parameter int N_ENTRIES = 8);
    import task_conflict_checker_pkg::*;
    localparam int LOG_N = $clog2(N_ENTRIES);
    logic             s_rvalid;
    task_t            s_rdata;
    cq_slice_slot_t   s_rslot;
    logic             s_rresp;
    logic             s_rresp_valid;
    logic             m_valid;
    logic             m_ready;
    task_t            m_task;
    cq_slice_slot_t   m_slot;
    logic [LOG_N-1:0] m_entry;
    logic             finish_valid;
    logic [LOG_N-1:0] finish_entry;
    logic [LOG_N:0]   active_count;
    logic [31:0]      stat_accepts;
    logic [31:0]      stat_rejects;
    modport slave (
        input  s_rvalid, s_rdata, s_rslot, m_ready, finish_valid, finish_entry,
        output s_rresp, s_rresp_valid, m_valid, m_task, m_slot, m_entry,
               active_count, stat_accepts, stat_rejects
    );
    modport master (
        output s_rvalid, s_rdata, s_rslot, m_ready, finish_valid, finish_entry,
        input  s_rresp, s_rresp_valid, m_valid, m_task, m_slot, m_entry,
               active_count, stat_accepts, stat_rejects
    );
endinterface

// File: rtl/task_conflict_checker.sv
// task_conflict_checker: accepts/rejects FIFO head tasks by hint against an in-flight table.
// Optional accept/reject counters enabled with CONFLICT_STATS_EN.
module task_conflict_checker
    import task_conflict_checker_pkg::*;
#(
    parameter int ID        = 0,
    parameter int N_ENTRIES = 8,
    localparam int LOG_N    = $clog2(N_ENTRIES)
) (
    input logic                  clk,
    input logic                  rst,
    task_conflict_checker_if.slave bus
);
    if (ID < 0 || N_ENTRIES < 2 || (N_ENTRIES & (N_ENTRIES - 1)) != 0) begin : g_bad_cfg
        $error("task_conflict_checker: N_ENTRIES must be a power of 2 >= 2");
    end

    typedef enum logic [1:0] {IDLE, CHECK, RESP, ISSUE} state_t;

    state_t               state_q;
    task_t                task_q;
    cq_slice_slot_t       slot_q;
    logic [N_ENTRIES-1:0] valid_q, valid_d;
    hint_t                hint_q [N_ENTRIES];
    logic                 conflict_q, conflict_d;
    logic                 rresp_valid_q, m_valid_q;
    logic [LOG_N-1:0]     free_q, free_d;
    logic [LOG_N:0]       count_q, count_d;
    logic                 alloc, fin;

    // Descending scan so the lowest-index free entry wins.
    always_comb begin
        conflict_d = count_q == (LOG_N+1)'(N_ENTRIES);
        free_d = '0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            conflict_d = conflict_d | (valid_q[i] & (hint_q[i] == task_q.hint));
            free_d = valid_q[i] ? free_d : LOG_N'(i);
        end
    end

    assign alloc = state_q == RESP && !conflict_q;
    assign fin   = bus.finish_valid && valid_q[bus.finish_entry];

    always_comb begin
        valid_d = valid_q;
        if (fin) valid_d[bus.finish_entry] = 1'b0;
        if (alloc) valid_d[free_q] = 1'b1;
    end

    assign count_d = count_q + (LOG_N+1)'(alloc) - (LOG_N+1)'(fin);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            task_q        <= '0;
            slot_q        <= '0;
            valid_q       <= '0;
            conflict_q    <= 1'b0;
            free_q        <= '0;
            count_q       <= '0;
            rresp_valid_q <= 1'b0;
            m_valid_q     <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            count_q       <= count_d;
            rresp_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.s_rvalid) begin
                    task_q  <= bus.s_rdata;
                    slot_q  <= bus.s_rslot;
                    state_q <= CHECK;
                end
                CHECK: begin
                    conflict_q    <= conflict_d;
                    free_q        <= free_d;
                    rresp_valid_q <= 1'b1;
                    state_q       <= RESP;
                end
                RESP: begin
                    m_valid_q <= !conflict_q;
                    state_q   <= conflict_q ? IDLE : ISSUE;
                end
                ISSUE: if (bus.m_ready) begin
                    m_valid_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Hint storage needs no reset: it is only consulted through valid_q.
    always_ff @(posedge clk) begin
        if (alloc) hint_q[free_q] <= task_q.hint;
    end

    assign bus.s_rresp       = conflict_q;
    assign bus.s_rresp_valid = rresp_valid_q;
    assign bus.m_valid       = m_valid_q;
    assign bus.m_task        = task_q;
    assign bus.m_slot        = slot_q;
    assign bus.m_entry       = free_q;
    assign bus.active_count  = count_q;

`ifdef CONFLICT_STATS_EN
    logic [31:0] accepts_q, rejects_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accepts_q <= '0;
            rejects_q <= '0;
        end else if (state_q == RESP) begin
            accepts_q <= accepts_q + 32'(!conflict_q);
            rejects_q <= rejects_q + 32'(conflict_q);
        end
    end
    assign bus.stat_accepts = accepts_q;
    assign bus.stat_rejects = rejects_q;
`else
    assign bus.stat_accepts = '0;
    assign bus.stat_rejects = '0;
`endif
endmodule

// File: tb/tb_task_conflict_checker.sv
// tb_task_conflict_checker: scoreboard bench; a reference table model predicts responses and issues.
module tb_task_conflict_checker;
    import task_conflict_checker_pkg::*;

    typedef struct packed {
        task_t          t;
        cq_slice_slot_t s;
        logic [2:0]     e;
    } iss_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    bit   resp_q [$];
    iss_t issue_q [$];
    bit   mv [8];
    hint_t mh [8];
    int   cnt = 0;
    int   exp_acc = 0;
    int   exp_rej = 0;

    task_conflict_checker_if #(.N_ENTRIES(8)) bus ();

    task_conflict_checker #(.ID(0), .N_ENTRIES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats();
`ifdef CONFLICT_STATS_EN
        chk("stat_acc", bus.stat_accepts, exp_acc);
        chk("stat_rej", bus.stat_rejects, exp_rej);
`else
        chk("stat_acc", bus.stat_accepts, 0);
        chk("stat_rej", bus.stat_rejects, 0);
`endif
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.s_rresp_valid) begin
                if (resp_q.size() == 0) chk("resp_unexp", 1, 0);
                else begin
                    bit r;
                    r = resp_q.pop_front();
                    chk("rresp", bus.s_rresp, r);
                end
            end
            if (bus.m_valid && bus.m_ready) begin
                if (issue_q.size() == 0) chk("issue_unexp", 1, 0);
                else begin
                    iss_t x;
                    x = issue_q.pop_front();
                    chk("m_task", bus.m_task, x.t);
                    chk("m_slot", 32'(bus.m_slot), 32'(x.s));
                    chk("m_entry", 32'(bus.m_entry), 32'(x.e));
                end
            end
        end
    end

    task automatic present(input hint_t h, input int fin_e = -1, input int hold = 0, input bit abort = 0);
        bit   rej;
        int   fe;
        int   n;
        iss_t x;
        rej = cnt == 8;
        fe = -1;
        for (int i = 0; i < 8; i++) begin
            if (mv[i] && mh[i] == h) rej = 1;
            if (!mv[i] && fe < 0) fe = i;
        end
        x.t.hint = h;
        x.t.payload = 24'($urandom);
        x.s = 4'($urandom);
        x.e = 3'(fe);
        resp_q.push_back(rej);
        if (!rej) issue_q.push_back(x);
        bus.m_ready = hold == 0;
        bus.s_rdata = x.t;
        bus.s_rslot = x.s;
        bus.s_rvalid = 1'b1;
        @(posedge clk); #1;
        bus.s_rvalid = 1'b0;
        bus.s_rdata = '1;
        n = 0;
        while (!bus.s_rresp_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("resp_lat", n, 1);
        if (fin_e >= 0) begin
            bus.finish_valid = 1'b1;
            bus.finish_entry = 3'(fin_e);
        end
        @(posedge clk); #1;
        bus.finish_valid = 1'b0;
        if (rej) exp_rej++;
        else begin
            exp_acc++;
            mv[fe] = 1;
            mh[fe] = h;
            cnt++;
        end
        if (fin_e >= 0 && mv[fin_e] && fin_e != fe) begin
            mv[fin_e] = 0;
            cnt--;
        end
        if (rej) chk("no_issue", bus.m_valid, 0);
        else begin
            for (int k = 0; k < hold; k++) begin
                chk("hold_valid", bus.m_valid, 1);
                chk("hold_task", bus.m_task, x.t);
                chk("hold_noresp", bus.s_rresp_valid, 0);
                @(posedge clk); #1;
            end
            if (abort) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_mvalid", bus.m_valid, 0);
                chk("rst_count", bus.active_count, 0);
                issue_q.delete();
                for (int i = 0; i < 8; i++) mv[i] = 0;
                cnt = 0;
                exp_acc = 0;
                exp_rej = 0;
                chk_stats();
                bus.m_ready = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            bus.m_ready = 1'b1;
            n = 0;
            while (!(bus.m_valid && bus.m_ready) && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            chk("issue_timeout", n < 20, 1);
            @(posedge clk); #1;
            chk("issue_done", bus.m_valid, 0);
        end
        chk("active_count", bus.active_count, cnt);
    endtask

    task automatic do_finish(input int e);
        bus.finish_valid = 1'b1;
        bus.finish_entry = 3'(e);
        @(posedge clk); #1;
        bus.finish_valid = 1'b0;
        if (mv[e]) begin
            mv[e] = 0;
            cnt--;
        end
        chk("fin_count", bus.active_count, cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_rvalid = 1'b0;
        bus.s_rdata = '0;
        bus.s_rslot = '0;
        bus.m_ready = 1'b1;
        bus.finish_valid = 1'b0;
        bus.finish_entry = '0;
        #3;
        chk("rst_rresp_valid", bus.s_rresp_valid, 0);
        chk("rst_rresp", bus.s_rresp, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_task", bus.m_task, 0);
        chk("rst_m_slot", 32'(bus.m_slot), 0);
        chk("rst_m_entry", 32'(bus.m_entry), 0);
        chk("rst_count", bus.active_count, 0);
        chk_stats();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        present(8'h05);
        present(8'h05);
        chk_stats();
        for (int i = 0; i < 7; i++) present(8'h10 + 8'(i));
        present(8'h09);
        do_finish(3);
        present(8'h09);
        do_finish(0);
        present(8'h20, -1, 10);
        do_finish(1);
        do_finish(2);
        present(8'h21, 4);
        do_finish(4);
        present(8'h22, -1, 3, 1);
        chk_stats();
        present(8'h05);
        present(8'h05);
        chk_stats();
        repeat (3) @(posedge clk);
        #1;
        chk("resp_q_left", resp_q.size(), 0);
        chk("issue_q_left", issue_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
